sap_controller: RTL and testbench

SAP_CONTROLLER -- requirements
Module: sap_controller

---
 rtl/sap_controller.sv | 139 +++++++++++++
 tb/tb_sap_controller.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_controller.sv
// SAP-style micro-sequencer: three-cycle FETCH/DECODE/EXEC loop that drives
// register enables, source selects and ALU op into an external datapath.
package sap_pkg;
  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5
  } alu_op_e;
endpackage

module sap_controller
  import sap_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [3:0]   pc_addr,
  input  logic [7:0]   instr_data,
  input  logic         z_in,
  output alu_op_e      op,
  output logic         en_A,
  output logic         en_B,
  output logic         sel_A,
  output logic         sel_B,
  output logic         load_out,
  output logic [N-1:0] imm_data,
  output logic         busy,
  output logic         halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDA  = 4'h1,
    OP_LDB  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_OUTA = 4'h8,
    OP_LDAB = 4'h9,
    OP_LDBB = 4'hA,
    OP_JZ   = 4'hB,
    OP_JMP  = 4'hC,
    OP_RSVD_D = 4'hD,
    OP_RSVD_E = 4'hE,
    OP_HLT  = 4'hF
  } opcode_e;

  state_e     state;
  logic [3:0] pc;
  logic [7:0] ir;
  opcode_e    opc;

  assign pc_addr = pc;
  assign opc     = opcode_e'(ir[7:4]);

  // Controls are registered on the DECODE->EXEC edge so they are visible
  // exactly during the EXEC cycle; the default clears make them one-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      op       <= ALU_PASS;
      en_A     <= 1'b0;
      en_B     <= 1'b0;
      sel_A    <= 1'b0;
      sel_B    <= 1'b0;
      load_out <= 1'b0;
      imm_data <= '0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      en_A     <= 1'b0;
      en_B     <= 1'b0;
      load_out <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          ir    <= instr_data;
          pc    <= pc + 4'd1;
          state <= S_DECODE;
        end
        S_DECODE: begin
          imm_data <= N'(ir[3:0]);
          state    <= S_EXEC;
          case (opc)
            OP_LDA:  begin en_A <= 1'b1; sel_A <= 1'b0; end
            OP_LDB:  begin en_B <= 1'b1; sel_B <= 1'b0; end
            OP_LDAB: begin en_A <= 1'b1; sel_A <= 1'b1; end
            OP_LDBB: begin en_B <= 1'b1; sel_B <= 1'b1; end
            OP_ADD:  begin op <= ALU_ADD;  load_out <= 1'b1; end
            OP_SUB:  begin op <= ALU_SUB;  load_out <= 1'b1; end
            OP_AND:  begin op <= ALU_AND;  load_out <= 1'b1; end
            OP_OR:   begin op <= ALU_OR;   load_out <= 1'b1; end
            OP_XOR:  begin op <= ALU_XOR;  load_out <= 1'b1; end
            OP_OUTA: begin op <= ALU_PASS; load_out <= 1'b1; end
            default: ;
          endcase
        end
        S_EXEC: begin
          if (opc == OP_HLT) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= S_FETCH;
            // Jump target overrides the increment already applied in FETCH.
            if (opc == OP_JMP || (opc == OP_JZ && z_in))
              pc <= ir[3:0];
          end
        end
        S_HALT: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_controller.sv
// Scoreboard bench for sap_controller: expected control pulses are queued as
// programs are loaded and checked by a monitor when the DUT emits them.
module tb_sap_controller;
  import sap_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] pc_addr;
  logic [7:0] instr_data;
  logic       z_in = 1'b0;
  alu_op_e    op;
  logic       en_A, en_B, sel_A, sel_B, load_out;
  logic [7:0] imm_data;
  logic       busy, halted;

  logic [7:0] rom [16];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  typedef struct {
    int         c;
    logic       a;
    logic       b;
    logic       lo;
    logic       sel;
    logic [7:0] imm;
    alu_op_e    o;
  } pulse_t;
  pulse_t exp_q [$];

  sap_controller #(.N(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pc_addr(pc_addr),
    .instr_data(instr_data), .z_in(z_in), .op(op), .en_A(en_A), .en_B(en_B),
    .sel_A(sel_A), .sel_B(sel_B), .load_out(load_out), .imm_data(imm_data),
    .busy(busy), .halted(halted)
  );

  assign instr_data = rom[pc_addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse the DUT emits must match the head of the expected queue.
  always @(negedge clk) begin
    if (en_A || en_B || load_out) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse cyc=%0d en_A=%b en_B=%b load_out=%b required none",
                 cyc, en_A, en_B, load_out);
      end else begin
        pulse_t e;
        logic   bad;
        e   = exp_q.pop_front();
        bad = (cyc !== e.c) || (en_A !== e.a) || (en_B !== e.b) || (load_out !== e.lo);
        if (e.a && (sel_A !== e.sel || imm_data !== e.imm)) bad = 1'b1;
        if (e.b && (sel_B !== e.sel || imm_data !== e.imm)) bad = 1'b1;
        if (e.lo && op !== e.o) bad = 1'b1;
        if (bad) begin
          miscompares++;
          $display("FAIL pulse got cyc=%0d A=%b B=%b lo=%b selA=%b selB=%b imm=%h op=%0d required cyc=%0d A=%b B=%b lo=%b sel=%b imm=%h op=%0d",
                   cyc, en_A, en_B, load_out, sel_A, sel_B, imm_data, op,
                   e.c, e.a, e.b, e.lo, e.sel, e.imm, e.o);
        end
      end
    end
  end

  function automatic void push(int c, logic a, logic b, logic lo, logic sel,
                               logic [7:0] imm, alu_op_e o);
    pulse_t e;
    e = '{c: c, a: a, b: b, lo: lo, sel: sel, imm: imm, o: o};
    exp_q.push_back(e);
  endfunction

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    z_in  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic kick(output int s);
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL %s_pending got %0d outstanding pulses required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    fill_rom(8'hF0);
    reset = 1'b1;
    start = 1'b1;
    tick();
    tick();
    vectors++;
    if ({pc_addr, en_A, en_B, sel_A, sel_B, load_out, busy, halted} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got pc=%h eA=%b eB=%b sA=%b sB=%b lo=%b busy=%b halted=%b required all 0",
               pc_addr, en_A, en_B, sel_A, sel_B, load_out, busy, halted);
    end
    vectors++;
    if (imm_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_imm got %h required 00", imm_data);
    end
    vectors++;
    if (op !== ALU_PASS) begin
      miscompares++;
      $display("FAIL reset_op got %0d required %0d", op, ALU_PASS);
    end
    reset = 1'b0;
    start = 1'b0;
    tick();
    tick();
    vectors++;
    if (busy !== 1'b0 || pc_addr !== 4'd0) begin
      miscompares++;
      $display("FAIL idle_hold got busy=%b pc=%h required busy=0 pc=0", busy, pc_addr);
    end
  endtask

  task automatic test_program();
    int s;
    do_reset();
    fill_rom(8'h00);
    rom[0] = 8'h1A; rom[1] = 8'h25; rom[2] = 8'h30; rom[3] = 8'hF0;
    kick(s);
    push(s + 2, 1, 0, 0, 0, 8'h0A, ALU_PASS);
    push(s + 5, 0, 1, 0, 0, 8'h05, ALU_PASS);
    push(s + 8, 0, 0, 1, 0, 8'h00, ALU_ADD);
    vectors++;
    if (busy !== 1'b1 || pc_addr !== 4'd0) begin
      miscompares++;
      $display("FAIL prog_fetch0 got busy=%b pc=%h required busy=1 pc=0", busy, pc_addr);
    end
    wait_cyc(s + 11);
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++;
      $display("FAIL prog_early_halt got halted=%b at cycle 11 required 0", halted);
    end
    tick();
    vectors++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc_addr !== 4'd4) begin
      miscompares++;
      $display("FAIL prog_halt got halted=%b busy=%b pc=%h required 1 0 4", halted, busy, pc_addr);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    vectors++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc_addr !== 4'd4) begin
      miscompares++;
      $display("FAIL halt_start got halted=%b busy=%b pc=%h required 1 0 4", halted, busy, pc_addr);
    end
    check_drained("program");
  endtask

  task automatic test_alu_ops();
    int s;
    logic [7:0] prog [14];
    prog = '{8'h17, 8'h93, 8'h2C, 8'hA1, 8'h80, 8'h3F, 8'h42, 8'h53,
             8'h64, 8'h75, 8'h00, 8'hD0, 8'hE0, 8'hF0};
    do_reset();
    fill_rom(8'h00);
    for (int i = 0; i < 14; i++) rom[i] = prog[i];
    kick(s);
    push(s + 2,  1, 0, 0, 0, 8'h07, ALU_PASS);
    push(s + 5,  1, 0, 0, 1, 8'h03, ALU_PASS);
    push(s + 8,  0, 1, 0, 0, 8'h0C, ALU_PASS);
    push(s + 11, 0, 1, 0, 1, 8'h01, ALU_PASS);
    push(s + 14, 0, 0, 1, 0, 8'h00, ALU_PASS);
    push(s + 17, 0, 0, 1, 0, 8'h0F, ALU_ADD);
    push(s + 20, 0, 0, 1, 0, 8'h02, ALU_SUB);
    push(s + 23, 0, 0, 1, 0, 8'h03, ALU_AND);
    push(s + 26, 0, 0, 1, 0, 8'h04, ALU_OR);
    push(s + 29, 0, 0, 1, 0, 8'h05, ALU_XOR);
    wait_cyc(s + 42);
    vectors++;
    if (halted !== 1'b1 || pc_addr !== 4'd14) begin
      miscompares++;
      $display("FAIL alu_halt got halted=%b pc=%h required 1 e", halted, pc_addr);
    end
    vectors++;
    if (sel_A !== 1'b1 || sel_B !== 1'b1 || op !== ALU_XOR) begin
      miscompares++;
      $display("FAIL alu_hold got selA=%b selB=%b op=%0d required 1 1 %0d", sel_A, sel_B, op, ALU_XOR);
    end
    check_drained("alu_ops");
  endtask

  task automatic test_jmp();
    int s;
    do_reset();
    fill_rom(8'h00);
    rom[0] = 8'hC3; rom[1] = 8'h11; rom[2] = 8'h21; rom[3] = 8'hF0;
    kick(s);
    wait_cyc(s + 3);
    vectors++;
    if (pc_addr !== 4'd3) begin
      miscompares++;
      $display("FAIL jmp_target got pc=%h required 3", pc_addr);
    end
    wait_cyc(s + 6);
    vectors++;
    if (halted !== 1'b1 || pc_addr !== 4'd4) begin
      miscompares++;
      $display("FAIL jmp_halt got halted=%b pc=%h required 1 4", halted, pc_addr);
    end
    check_drained("jmp");
  endtask

  task automatic test_jz(input logic z, input logic [3:0] target);
    int s;
    do_reset();
    fill_rom(8'hF0);
    rom[0] = 8'hB5;
    kick(s);
    z_in = ~z;
    wait_cyc(s + 2);
    z_in = z;
    wait_cyc(s + 3);
    z_in = ~z;
    vectors++;
    if (pc_addr !== target) begin
      miscompares++;
      $display("FAIL jz_z%0b got pc=%h required %h", z, pc_addr, target);
    end
    wait_cyc(s + 6);
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL jz_halt_z%0b got halted=%b required 1", z, halted);
    end
    check_drained("jz");
  endtask

  task automatic test_wrap();
    int s;
    do_reset();
    fill_rom(8'h00);
    kick(s);
    for (int k = 0; k <= 17; k++) begin
      logic [3:0] want;
      want = 4'(k);
      wait_cyc(s + 3 * k);
      vectors++;
      if (pc_addr !== want || busy !== 1'b1 || halted !== 1'b0) begin
        miscompares++;
        $display("FAIL wrap_fetch%0d got pc=%h busy=%b halted=%b required pc=%h busy=1 halted=0",
                 k, pc_addr, busy, halted, want);
      end
    end
    check_drained("wrap");
  endtask

  task automatic test_reset_exec();
    int s;
    do_reset();
    fill_rom(8'hF0);
    rom[0] = 8'h1A;
    kick(s);
    push(s + 2, 1, 0, 0, 0, 8'h0A, ALU_PASS);
    wait_cyc(s + 2);
    vectors++;
    if (en_A !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_exec_pre got en_A=%b required 1", en_A);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({pc_addr, en_A, en_B, sel_A, sel_B, load_out, busy, halted} !== 11'b0 ||
        imm_data !== 8'h00 || op !== ALU_PASS) begin
      miscompares++;
      $display("FAIL rst_exec got pc=%h eA=%b eB=%b sA=%b sB=%b lo=%b busy=%b halted=%b imm=%h op=%0d required all 0 op=%0d",
               pc_addr, en_A, en_B, sel_A, sel_B, load_out, busy, halted, imm_data, op, ALU_PASS);
    end
    repeat (4) tick();
    vectors++;
    if (busy !== 1'b0 || pc_addr !== 4'd0) begin
      miscompares++;
      $display("FAIL rst_exec_idle got busy=%b pc=%h required 0 0", busy, pc_addr);
    end
    check_drained("reset_exec");
  endtask

  task automatic test_start_busy();
    int s;
    do_reset();
    fill_rom(8'hF0);
    rom[0] = 8'h1A; rom[1] = 8'h00;
    kick(s);
    start = 1'b1;
    push(s + 2, 1, 0, 0, 0, 8'h0A, ALU_PASS);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] want;
      want = 4'(k);
      wait_cyc(s + 3 * k);
      vectors++;
      if (pc_addr !== want) begin
        miscompares++;
        $display("FAIL busy_start_fetch%0d got pc=%h required %h", k, pc_addr, want);
      end
    end
    wait_cyc(s + 9);
    vectors++;
    if (halted !== 1'b1 || pc_addr !== 4'd3) begin
      miscompares++;
      $display("FAIL busy_start_halt got halted=%b pc=%h required 1 3", halted, pc_addr);
    end
    start = 1'b0;
    check_drained("start_busy");
  endtask

  initial begin
    test_reset();
    test_program();
    test_alu_ops();
    test_jmp();
    test_jz(1'b1, 4'd5);
    test_jz(1'b0, 4'd1);
    test_wrap();
    test_reset_exec();
    test_start_busy();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion required finish before 200000");
    $fatal(1);
  end

endmodule
